// File: rtl/regfile_pkg.sv
// Shared defaults and reset-content builder for the scoreboarded register file.
package regfile_pkg;
  localparam int XLEN_DEF     = 64;
  localparam int NREGS_DEF    = 32;
  localparam int ZERO_REG_DEF = 31;

  // Reset value of register idx; callers cast down to XLEN.
  function automatic logic [63:0] init_val(int idx, int init_index, int zero_reg);
    if (init_index != 0 && idx != zero_reg) return 64'(idx);
    return '0;
  endfunction
endpackage

// File: rtl/regfile_sb_if.sv
// Read/write/mark bus of the scoreboarded register file.
interface regfile_sb_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd;
  logic [NRD-1:0]      rdy;
  logic                we;
  logic [AW-1:0]       wa;
  logic [XLEN-1:0]     wd;
  logic                mark_en;
  logic [AW-1:0]       mark_addr;
  logic                flush;
  logic [NREGS-1:0]    busy;

  modport master (output ra, we, wa, wd, mark_en, mark_addr, flush,
                  input  rd, rdy, busy);
  modport slave  (input  ra, we, wa, wd, mark_en, mark_addr, flush,
                  output rd, rdy, busy);
endinterface

// File: rtl/regfile_rdport.sv
// One read port: zero-register, write-through bypass and ready reporting.
module regfile_rdport #(
  parameter int XLEN     = 64,
  parameter int AW       = 5,
  parameter int ZERO_REG = 31
) (
  input  logic [AW-1:0]   ra,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic [XLEN-1:0] rf_data,
  input  logic            rf_busy,
  output logic [XLEN-1:0] rd,
  output logic            rdy
);
  localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

  // Zero register wins even over a bypassed write to it.
  always_comb begin
    rd  = rf_data;
    rdy = ~rf_busy;
    if (ra == ZA) begin
      rd  = '0;
      rdy = 1'b1;
    end else if (we && wa == ra) begin
      rd  = wd;
      rdy = 1'b1;
    end
  end
endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with a per-register pending-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int NREGS      = NREGS_DEF,
  parameter int NRD        = 2,
  parameter int ZERO_REG   = ZERO_REG_DEF,
  parameter int INIT_INDEX = 1
) (
  input  logic         clk,
  input  logic         reset,
  regfile_sb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZA = AW'(ZERO_REG);

  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0]           busy, busy_nxt;
  logic [NRD-1:0][AW-1:0]     ra_v;
  logic [NRD-1:0][XLEN-1:0]   rd_v;
  logic [NRD-1:0]             rdy_v;

  // Busy priority: flush > mark > write-clear (reset handled in the flop).
  always_comb begin
    busy_nxt = busy;
    if (bus.flush) begin
      busy_nxt = '0;
    end else begin
      if (bus.we && bus.wa != ZA)               busy_nxt[bus.wa]        = 1'b0;
      if (bus.mark_en && bus.mark_addr != ZA)   busy_nxt[bus.mark_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= XLEN'(init_val(i, INIT_INDEX, ZERO_REG));
      busy <= '0;
    end else begin
      if (bus.we && bus.wa != ZA) regs[bus.wa] <= bus.wd;
      busy <= busy_nxt;
    end
  end

  assign ra_v     = bus.ra;
  assign bus.rd   = rd_v;
  assign bus.rdy  = rdy_v;
  assign bus.busy = busy;

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regfile_rdport #(.XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG)) u_rdport (
      .ra      (ra_v[p]),
      .we      (bus.we),
      .wa      (bus.wa),
      .wd      (bus.wd),
      .rf_data (regs[ra_v[p]]),
      .rf_busy (busy[ra_v[p]]),
      .rd      (rd_v[p]),
      .rdy     (rdy_v[p])
    );
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with per-register pending-write scoreboard, successor to the single-write/two-read LEGv8 register file in the pipelined datapath. It provides same-cycle write-through bypass, a hard-wired zero register, and index-pattern reset contents. Each read port also reports whether its operand is ready, so decode can detect load-use and long-latency hazards.

## Interface
- XLEN, 64, data width in bits
- NREGS, 32, number of architectural registers (power of 2, ≥ 4)
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 31, index that always reads 0 and ignores writes/marks
- INIT_INDEX, 1, reset contents: 1 → reg[i] = i, 0 → all zero (ZERO_REG always 0)
- AW (localparam) = $clog2(NREGS)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high
- ra  in  NRD*AW  read addresses, port p at bits [p*AW +: AW]
- rd  out  NRD*XLEN  read data, port p at bits [p*XLEN +: XLEN]
- rdy  out  NRD  port p operand ready
- we  in  1  write enable
- wa  in  AW  write address
- wd  in  XLEN  write data
- mark_en  in  1  mark register mark_addr as pending (producer issued)
- mark_addr  in  AW  register to mark
- flush  in  1  clear all pending bits
- busy  out  NREGS  pending bit vector (registered)

## Operation
- Storage: NREGS×XLEN array plus NREGS-bit busy vector, both flops.
- Reset (async, any time): array loaded per INIT_INDEX, busy = 0; reads combinationally reflect reset contents while reset is held.
- Write: on clk edge with we=1 and wa≠ZERO_REG, reg[wa] ← wd and busy[wa] ← 0 (unless re-marked, below).
- Mark: on clk edge with mark_en=1 and mark_addr≠ZERO_REG, busy[mark_addr] ← 1.
- Same-cycle write and mark to same address: busy stays 1 (new producer wins); data still written.
- Flush: on clk edge busy ← 0 for all; a mark in the same cycle is dropped; a write in the same cycle still commits data.
- Priority for busy: reset > flush > mark > write-clear.
- Read port p (combinational): if ra_p = ZERO_REG → rd = 0, rdy = 1; else if we=1 and wa = ra_p → rd = wd, rdy = 1 (bypass); else rd = reg[ra_p], rdy = ~busy[ra_p].
- Bypass ignores mark_en/flush of the same cycle; it reflects only the write.
- All read ports are independent; identical addresses on several ports return identical results.

## Timing
- Read: zero-latency combinational from ra/we/wa/wd to rd/rdy.
- Write and mark: take effect at the next rising edge and are visible on non-bypassed reads in the following cycle.
- busy output: registered, updates at the edge; reset value all zero.
- rd/rdy are combinational, so they have no independent reset value. During reset: rd = reset contents, rdy = all ones.
- No handshake stalls; the block accepts one write and one mark every cycle.

## Structure
- Package regfile_pkg: default XLEN/NREGS/ZERO_REG constants and the function that builds reset contents from INIT_INDEX.
- Sub-module regfile_rdport (one instance per read port via generate): zero-register check, bypass mux and rdy logic, parametrised on XLEN/AW/ZERO_REG.
- Top holds the array, busy vector and update logic.

## Test plan
- Reset then read ports 0/1 at ra=5, ra=31 → rd=5, rd=0, rdy=11, busy=0; with INIT_INDEX=0, ra=5 → rd=0.
- we=1, wa=3, wd=0xDEAD_BEEF while ra0=3 → rd0=0xDEADBEEF in the same cycle. The next cycle, with we=0, still reads 0xDEADBEEF. Writing wa=31 leaves ra=31 reading 0.
- mark_en at addr 7 → next cycle rdy0=0 for ra0=7 and busy[7]=1. Then we at addr 7 with wd=42 → same-cycle rd0=42, rdy0=1. After the edge, busy[7]=0.
- The same cycle has we and mark_en at addr 9 → after the edge busy[9]=1 and reg[9]=wd. mark_en at addr 31 → busy[31] stays 0.
- Marks at 2, 4, 6, then flush with a concurrent mark at 8 and a write to 2 (wd=99) → busy=0 and reg[2]=99.
- Assert reset asynchronously mid-cycle after writes/marks → busy and array return to reset contents immediately, without waiting for clk. NRD=4 instance: all four ports read distinct addresses correctly.
